// File: rtl/rs_flop_bank.sv
// Bank of WIDTH clocked set/reset flags with MODE-selected S=R=1 policy, change pulses and a conflict counter.
// Define RS_FLOP_BANK_SYNC_EN to pass S/R/E through 2-flop synchronisers (CLR stays direct).
module rs_flop_bank #(
    parameter int              WIDTH = 8,
    parameter int              MODE  = 0,
    parameter logic [WIDTH-1:0] INIT = '0,
    parameter int              CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST_L,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             E,
    input  logic             CLR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_L,
    output logic [WIDTH-1:0] CHG,
    output logic             CONFLICT,
    output logic [CNT_W-1:0] CONF_CNT
);

    generate
        if (MODE < 0 || MODE > 3 || WIDTH < 1 || WIDTH > 32 || CNT_W < 1 || CNT_W > 16) begin : g_bad_param
            $error("rs_flop_bank: illegal parameter value");
        end
    endgenerate

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [WIDTH-1:0] s_i;
    logic [WIDTH-1:0] r_i;
    logic             e_i;

`ifdef RS_FLOP_BANK_SYNC_EN
    logic [WIDTH-1:0] s_meta_q, s_sync_q;
    logic [WIDTH-1:0] r_meta_q, r_sync_q;
    logic             e_meta_q, e_sync_q;

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            s_meta_q <= '0;
            s_sync_q <= '0;
            r_meta_q <= '0;
            r_sync_q <= '0;
            e_meta_q <= 1'b0;
            e_sync_q <= 1'b0;
        end else begin
            s_meta_q <= S;
            s_sync_q <= s_meta_q;
            r_meta_q <= R;
            r_sync_q <= r_meta_q;
            e_meta_q <= E;
            e_sync_q <= e_meta_q;
        end
    end

    assign s_i = s_sync_q;
    assign r_i = r_sync_q;
    assign e_i = e_sync_q;
`else
    assign s_i = S;
    assign r_i = R;
    assign e_i = E;
`endif

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] chg_q, chg_d;
    logic             conflict_q, conflict_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             conf_cyc;

    // Next-state decode: CLR beats the gate, the gate beats S/R.
    always_comb begin
        q_d        = q_q;
        conflict_d = conflict_q;
        cnt_d      = cnt_q;
        conf_cyc   = !CLR && e_i && (|(s_i & r_i));
        if (CLR) begin
            q_d        = INIT;
            conflict_d = 1'b0;
            cnt_d      = '0;
        end else if (e_i) begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({s_i[i], r_i[i]})
                    2'b10: q_d[i] = 1'b1;
                    2'b01: q_d[i] = 1'b0;
                    2'b11: begin
                        case (MODE)
                            0:       q_d[i] = 1'b0;
                            1:       q_d[i] = 1'b1;
                            2:       q_d[i] = q_q[i];
                            default: q_d[i] = ~q_q[i];
                        endcase
                    end
                    default: q_d[i] = q_q[i];
                endcase
            end
            if (conf_cyc) begin
                conflict_d = 1'b1;
                cnt_d      = sat_inc(cnt_q);
            end
        end
        chg_d = q_d ^ q_q;
    end

    // State registers; reset returns the bank to INIT with no pending pulses.
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            q_q        <= INIT;
            chg_q      <= '0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            q_q        <= q_d;
            chg_q      <= chg_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
        end
    end

    assign Q        = q_q;
    assign Q_L      = ~q_q;
    assign CHG      = chg_q;
    assign CONFLICT = conflict_q;
    assign CONF_CNT = cnt_q;

endmodule
